// File: rtl/gate_stim_seq.sv
`default_nettype none
// ============================================================================
// gate_stim_seq : sweeps (a,b) through 00..11 for the gate bank and
//                 counts response mismatches against the ideal truth table.
// Revision      : 1.0
// ============================================================================
module gate_stim_seq #(
  parameter int HOLD_W = 8,
  parameter int REP_W  = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [REP_W-1:0]  repeat_count,
  input  logic [6:0]        resp,
  output logic              a,
  output logic              b,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_seen,
  output logic [1:0]        fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t            state;
  logic [HOLD_W-1:0] hold_lat;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_lat;
  logic [REP_W-1:0]  sweep;
  logic [1:0]        vec;
  logic [6:0]        exp_resp;
  logic              mismatch;

  // Ideal {not,and,nand,or,nor,xor,xnor} of the vector currently applied.
  always_comb begin
    exp_resp = {~vec[1], vec[1] & vec[0], ~(vec[1] & vec[0]), vec[1] | vec[0],
                ~(vec[1] | vec[0]), vec[1] ^ vec[0], ~(vec[1] ^ vec[0])};
    mismatch = (resp != exp_resp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_lat  <= '0;
      hold_cnt  <= '0;
      rep_lat   <= '0;
      sweep     <= '0;
      vec       <= 2'b00;
      a         <= 1'b0;
      b         <= 1'b0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      fail_seen <= 1'b0;
      fail_vec  <= 2'b00;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            hold_lat  <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
            rep_lat   <= (repeat_count == '0) ? REP_W'(1) : repeat_count;
            hold_cnt  <= '0;
            sweep     <= '0;
            vec       <= 2'b00;
            a         <= 1'b0;
            b         <= 1'b0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
            err_count <= '0;
            fail_seen <= 1'b0;
            fail_vec  <= 2'b00;
            state     <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          if (hold_cnt == hold_lat - HOLD_W'(1)) begin
            hold_cnt <= '0;
            state    <= S_SAMPLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        S_SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + ERR_W'(1);
            end
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              fail_vec  <= vec;
            end
          end
          if (vec != 2'b11) begin
            vec      <= vec + 2'b01;
            {a, b}   <= vec + 2'b01;
            state    <= S_DRIVE;
          end else if (sweep == rep_lat - REP_W'(1)) begin
            a         <= 1'b0;
            b         <= 1'b0;
            vec_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            sweep  <= sweep + REP_W'(1);
            vec    <= 2'b00;
            {a, b} <= 2'b00;
            state  <= S_DRIVE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_stim_seq.sv
`default_nettype none
// ============================================================================
// tb_gate_stim_seq : directed + randomized runs checked cycle by cycle
//                    against a timeline/arithmetic reference.
// Revision         : 1.0
// ============================================================================
module tb_gate_stim_seq;

  logic       clk = 1'b0;
  logic       rst, start, start5;
  logic [7:0] hold_cycles;
  logic [3:0] repeat_count;
  logic [6:0] resp;
  logic [6:0] resp5;
  logic       a, b, vec_valid, busy, done, fail_seen;
  logic [7:0] err_count;
  logic [1:0] fail_vec;
  logic       a5, b5, vec_valid5, busy5, done5, fail_seen5;
  logic [4:0] err_count5;
  logic [1:0] fail_vec5;

  logic [6:0] mask [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] gate(input logic x, input logic y);
    return {~x, x & y, ~(x & y), x | y, ~(x | y), x ^ y, ~(x ^ y)};
  endfunction

  // Gate bank stand-in: ideal response with a per-vector fault mask.
  always_comb resp = gate(a, b) ^ mask[{a, b}];
  assign resp5 = 7'h00;

  gate_stim_seq dut (
    .clk(clk), .rst(rst), .start(start), .hold_cycles(hold_cycles),
    .repeat_count(repeat_count), .resp(resp), .a(a), .b(b),
    .vec_valid(vec_valid), .busy(busy), .done(done), .err_count(err_count),
    .fail_seen(fail_seen), .fail_vec(fail_vec)
  );

  gate_stim_seq #(.ERR_W(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .hold_cycles(hold_cycles),
    .repeat_count(repeat_count), .resp(resp5), .a(a5), .b(b5),
    .vec_valid(vec_valid5), .busy(busy5), .done(done5), .err_count(err_count5),
    .fail_seen(fail_seen5), .fail_vec(fail_vec5)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string ctx, input int ea, input int eb,
                            input int ev, input int ebusy, input int edone);
    chk({ctx, " a"},         int'(a),         ea);
    chk({ctx, " b"},         int'(b),         eb);
    chk({ctx, " vec_valid"}, int'(vec_valid), ev);
    chk({ctx, " busy"},      int'(busy),      ebusy);
    chk({ctx, " done"},      int'(done),      edone);
  endtask

  task automatic check_result(input string ctx, input int ee, input int efs, input int efv);
    chk({ctx, " err_count"}, int'(err_count), ee);
    chk({ctx, " fail_seen"}, int'(fail_seen), efs);
    chk({ctx, " fail_vec"},  int'(fail_vec),  efv);
  endtask

  // mode: 0 quiet, 1 start pulse during vector 01, 2 random start pulses.
  // Modes 1/2 also scramble hold/repeat inputs right after the start edge.
  task automatic run(input int h, input int r, input int mode,
                     input int abort_k, input int rst_len);
    int he, re, total, nerr, fv, idx;
    bit fs;
    string ctx;
    he = (h == 0) ? 1 : h;
    re = (r == 0) ? 1 : r;
    total = re * 4 * (he + 1);
    nerr = 0; fs = 1'b0; fv = 0;
    for (int v = 0; v < 4; v++) begin
      if (mask[v] != 7'h00) begin
        nerr += re;
        if (!fs) begin fs = 1'b1; fv = v; end
      end
    end
    if (nerr > 255) nerr = 255;

    hold_cycles = 8'(h); repeat_count = 4'(r); start = 1'b1;
    step();
    start = 1'b0;
    if (mode != 0) begin
      hold_cycles = 8'($urandom); repeat_count = 4'($urandom);
    end
    for (int k = 1; k <= total + 1; k++) begin
      ctx = $sformatf("h%0d r%0d c%0d", h, r, k);
      if (k <= total) begin
        idx = ((k - 1) / (he + 1)) % 4;
        check_outs(ctx, (idx >> 1) & 1, idx & 1, 1, 1, 0);
      end else begin
        check_outs(ctx, 0, 0, 0, 1, 1);
        check_result(ctx, nerr, int'(fs), fv);
      end
      if (abort_k == k) begin
        start = 1'b0;
        rst = 1'b1;
        repeat (rst_len) step();
        rst = 1'b0;
        check_outs({ctx, " post-rst"}, 0, 0, 0, 0, 0);
        check_result({ctx, " post-rst"}, 0, 0, 0);
        for (int j = 0; j < total + 2; j++) begin
          step();
          chk({ctx, " abort no done"}, int'(done), 0);
          chk({ctx, " abort idle"}, int'(busy), 0);
        end
        return;
      end
      if (mode == 1)      start = (k == he + 2);
      else if (mode == 2) start = (k < total + 1) ? 1'($urandom) : 1'b0;
      else                start = 1'b0;
      step();
    end
    start = 1'b0;
    check_outs({ctx, " after"}, 0, 0, 0, 0, 0);
    check_result({ctx, " after"}, nerr, int'(fs), fv);
    step();
  endtask

  initial begin
    int h, r, ab;
    rst = 1'b1; start = 1'b0; start5 = 1'b0;
    hold_cycles = 8'd0; repeat_count = 4'd0;
    for (int v = 0; v < 4; v++) mask[v] = 7'h00;
    step(); step();
    rst = 1'b0;
    check_outs("reset", 0, 0, 0, 0, 0);
    check_result("reset", 0, 0, 0);
    chk("reset dut5 busy", int'(busy5), 0);
    chk("reset dut5 err", int'(err_count5), 0);

    // Ideal gate bank, hold=2, rep=1
    run(2, 1, 0, 0, 0);

    // AND output stuck at 1: mismatches on 00, 01, 10
    mask[0] = 7'h20; mask[1] = 7'h20; mask[2] = 7'h20; mask[3] = 7'h00;
    run(1, 1, 0, 0, 0);

    // Two-edge reset mid-run after an error has been counted
    mask[0] = 7'h01; mask[1] = 7'h00; mask[2] = 7'h00;
    run(1, 2, 0, 7, 2);

    // Zero hold/repeat treated as 1/1
    mask[0] = 7'h00;
    run(0, 0, 0, 0, 0);

    // Start during vector 01 ignored; then reset during vector 10
    run(2, 1, 1, 0, 0);
    run(2, 1, 0, 7, 1);

    // Saturation with a narrow error counter
    hold_cycles = 8'd1; repeat_count = 4'd15; start5 = 1'b1;
    step();
    start5 = 1'b0;
    for (int k = 1; k <= 121; k++) begin
      chk($sformatf("sat done5 c%0d", k), int'(done5), (k == 121) ? 1 : 0);
      if (k == 121) begin
        chk("sat err_count5", int'(err_count5), 31);
        chk("sat fail_seen5", int'(fail_seen5), 1);
        chk("sat fail_vec5", int'(fail_vec5), 0);
        chk("sat busy5", int'(busy5), 1);
      end
      step();
    end
    chk("sat busy5 after", int'(busy5), 0);
    chk("sat err_count5 hold", int'(err_count5), 31);

    // Randomized runs
    for (int n = 0; n < 12; n++) begin
      for (int v = 0; v < 4; v++)
        mask[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'h00;
      h = $urandom_range(0, 5);
      r = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      run(h, r, (n % 2 == 0) ? 2 : 0, ab, $urandom_range(1, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
